// File: rtl/codec_i2s_tx.sv
// Stereo I2S transmitter: buffers one left/right pair from the mixer and
// serializes it MSB-first in standard I2S framing with a divided BCLK.
module codec_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [15:0] left_i,
    input  logic [15:0] right_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        frame_o,
    output logic [7:0]  underrun_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        dacdat_o
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          dacdat_q, dacdat_d;
    logic          en_q;
    logic          run_q, run_d;
    logic          pend_full_q, pend_full_d;
    logic [15:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [15:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [7:0]    underrun_q, underrun_d;

    logic          tick, fall, fetch, accept;
    logic [4:0]    slot;
    logic [3:0]    sel;
    logic [15:0]   sample;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        fall   = run_q & tick & bclk_q;
        // First enabled cycle (en_q set, not yet running) or the 63->0 fall starts a frame.
        fetch  = enable_i & en_q & (~run_q | (fall & (bit_q == 6'd63)));
        accept = valid_i & ~pend_full_q;

        div_d       = div_q;
        bit_d       = bit_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        dacdat_d    = dacdat_q;
        run_d       = run_q;
        pend_full_d = accept | (pend_full_q & ~fetch);
        pend_l_d    = accept ? left_i  : pend_l_q;
        pend_r_d    = accept ? right_i : pend_r_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        underrun_d  = underrun_q;
        slot        = 5'd0;
        sel         = 4'd0;
        sample      = 16'd0;

        if (fetch) begin
            if (pend_full_q) begin
                hold_l_d = pend_l_q;
                hold_r_d = pend_r_q;
            end else if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
            end
        end

        if (!enable_i) begin
            div_d    = '0;
            bit_d    = 6'd0;
            bclk_d   = 1'b0;
            lrclk_d  = 1'b0;
            dacdat_d = 1'b0;
            run_d    = 1'b0;
        end else if (!run_q) begin
            run_d = en_q;
        end else begin
            div_d  = tick ? '0 : div_q + 1'b1;
            bclk_d = bclk_q ^ tick;
            if (fall) begin
                bit_d   = bit_q + 6'd1;
                lrclk_d = bit_d[5];
                // Slot bit 0 is the one-BCLK I2S delay; bits 1..16 carry MSB..LSB.
                slot    = bit_d[4:0];
                sel     = 4'd0 - slot[3:0];
                sample  = bit_d[5] ? hold_r_q : hold_l_q;
                dacdat_d = (slot != 5'd0 && slot <= 5'd16) ? sample[sel] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q       <= '0;
            bit_q       <= 6'd0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            dacdat_q    <= 1'b0;
            en_q        <= 1'b0;
            run_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_l_q    <= 16'd0;
            pend_r_q    <= 16'd0;
            hold_l_q    <= 16'd0;
            hold_r_q    <= 16'd0;
            underrun_q  <= 8'd0;
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            dacdat_q    <= dacdat_d;
            en_q        <= enable_i;
            run_q       <= run_d;
            pend_full_q <= pend_full_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ready_o    = ~pend_full_q;
    assign frame_o    = fetch;
    assign underrun_o = underrun_q;
    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign dacdat_o   = dacdat_q;
endmodule

// File: tb/tb_codec_i2s_tx.sv
// Scoreboard bench for codec_i2s_tx: stimulus queues the pair expected in each
// frame; a monitor collects bits at BCLK rises and checks them per frame.
module tb_codec_i2s_tx;
    localparam int DIV = 2;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] left = 16'd0;
    logic [15:0] right = 16'd0;
    logic        ready_o, frame_o, bclk_o, lrclk_o, dacdat_o;
    logic [7:0]  underrun_o;

    pair_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    codec_i2s_tx #(.BCLK_DIV(DIV)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .left_i     (left),
        .right_i    (right),
        .valid_i    (valid),
        .ready_o    (ready_o),
        .frame_o    (frame_o),
        .underrun_o (underrun_o),
        .bclk_o     (bclk_o),
        .lrclk_o    (lrclk_o),
        .dacdat_o   (dacdat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic exp_bit(input pair_t e, input int i);
        int s;
        logic [15:0] w;
        s = i % 32;
        w = (i < 32) ? e.l : e.r;
        if (s >= 1 && s <= 16) return w[16-s];
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    logic [63:0] rx_d = '0;
    logic [63:0] rx_lr = '0;
    int          idx = 0;
    bit          open_f = 0;
    logic        prev_bclk = 1'b0;

    task automatic finish_frame(input int n);
        pair_t e;
        logic [63:0] ed, el, mask;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_unexpected: got frame with %0d bits, expected none", n);
            return;
        end
        e = exp_q.pop_front();
        if (n == 0) return;
        ed = '0; el = '0; mask = '0;
        for (int i = 0; i < n; i++) begin
            mask[i] = 1'b1;
            el[i]   = (i >= 32);
            ed[i]   = exp_bit(e, i);
        end
        $display("frame: L=%h R=%h bits=%0d rx=%h", e.l, e.r, n, rx_d & mask);
        chk("frame_data", rx_d & mask, ed);
        chk("frame_lrclk", rx_lr & mask, el);
    endtask

    always @(negedge clk) begin
        if (frame_o) begin
            if (open_f) finish_frame(idx);
            open_f = 1;
            idx = 0;
        end else if (open_f && bclk_o && !prev_bclk) begin
            rx_d[idx]  = dacdat_o;
            rx_lr[idx] = lrclk_o;
            idx++;
            if (idx == 64) begin
                finish_frame(64);
                open_f = 0;
            end
        end
        prev_bclk = bclk_o;
    end

    // ---------------- stimulus ----------------
    task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, output int waited);
        bit ok;
        logic rdy;
        ok = 0;
        waited = 0;
        left = l; right = r; valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            rdy = ready_o;
            @(posedge clk);
            #1;
            ok = rdy;
            waited++;
        end
        valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: pair %h/%h not accepted, expected acceptance", l, r);
        end else begin
            $display("send: L=%h R=%h after %0d cycles", l, r, waited);
            chk("ready_low_after_accept", ready_o, 0);
        end
    endtask

    task automatic wait_fetch(input int max, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (frame_o) ok = 1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no fetch within %0d cycles, expected one", name, max);
        end
    endtask

    logic [15:0] pl[4] = '{16'h0001, 16'hA5A5, 16'h0000, 16'h7FFF};
    logic [15:0] pr[4] = '{16'hFFFF, 16'h5A5A, 16'h8000, 16'h0002};

    initial begin
        int w;
        int bad;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_bclk", bclk_o, 0);
        chk("rst_lrclk", lrclk_o, 0);
        chk("rst_dacdat", dacdat_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_frame", frame_o, 0);
        chk("rst_underrun", underrun_o, 0);

        // First pair pushed before the first fetch
        send(16'h8001, 16'h7FFE, w);
        expect_pair(16'h8001, 16'h7FFE);
        enable = 1'b1;
        wait_fetch(8, "first_fetch");
        chk("ready_at_fetch", ready_o, 0);
        @(posedge clk); #1;
        chk("ready_after_fetch", ready_o, 1);

        // Continuous feed
        for (int k = 0; k < 4; k++) begin
            send(pl[k], pr[k], w);
            expect_pair(pl[k], pr[k]);
            wait_fetch(600, "feed_fetch");
            chk("feed_ready_at_fetch", ready_o, 0);
            @(posedge clk); #1;
            chk("feed_ready_after_fetch", ready_o, 1);
        end
        chk("feed_underrun", underrun_o, 0);

        // Hold-off: second pair waits until the first has been fetched
        send(16'h1111, 16'h2222, w);
        expect_pair(16'h1111, 16'h2222);
        chk("holdoff_ready", ready_o, 0);
        send(16'h3333, 16'h4444, w);
        expect_pair(16'h3333, 16'h4444);
        chk("holdoff_waited", (w > 100), 1);
        wait_fetch(600, "holdoff_fetch");
        @(posedge clk); #1;
        chk("holdoff_underrun", underrun_o, 0);

        // Starvation: one pair then three empty frames (fourth repeat is the simultaneous case)
        send(16'h1234, 16'h5678, w);
        repeat (5) expect_pair(16'h1234, 16'h5678);
        wait_fetch(600, "starve_fetch0");
        wait_fetch(600, "starve_fetch1");
        wait_fetch(600, "starve_fetch2");
        wait_fetch(600, "starve_fetch3");
        chk("underrun_not_yet", underrun_o, 2);
        @(posedge clk); #1;
        chk("starve_underrun", underrun_o, 3);

        // Simultaneous accept and fetch with an empty buffer
        repeat (255) begin @(posedge clk); #1; end
        left = 16'hCAFE; right = 16'hBEEF; valid = 1'b1;
        @(negedge clk);
        chk("simul_frame", frame_o, 1);
        chk("simul_ready", ready_o, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        $display("send: L=cafe R=beef in fetch cycle");
        expect_pair(16'hCAFE, 16'hBEEF);
        chk("simul_ready_low", ready_o, 0);
        chk("simul_underrun", underrun_o, 4);

        // Disable mid-frame, accept a pair while disabled, re-enable
        wait_fetch(600, "simul_next_fetch");
        repeat (81) begin @(posedge clk); #1; end
        enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_pins", {bclk_o, lrclk_o, dacdat_o}, 0);
        send(16'h0F0F, 16'hF0F0, w);
        expect_pair(16'h0F0F, 16'hF0F0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bclk_o || lrclk_o || dacdat_o || frame_o) bad++;
        end
        @(posedge clk); #1;
        chk("dis_quiet_cycles", bad, 0);
        chk("dis_underrun_kept", underrun_o, 4);
        chk("dis_pending_kept", ready_o, 0);
        enable = 1'b1;
        wait_fetch(4, "reenable_fetch");
        @(posedge clk); #1;
        chk("reen_ready", ready_o, 1);
        chk("reen_underrun", underrun_o, 4);

        // Reset pulsed mid-frame
        repeat (120) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mrst_pins", {bclk_o, lrclk_o, dacdat_o}, 0);
        chk("mrst_ready", ready_o, 1);
        chk("mrst_frame", frame_o, 0);
        chk("mrst_underrun", underrun_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_pair(16'h0000, 16'h0000);
        wait_fetch(4, "post_reset_fetch");
        @(posedge clk); #1;
        chk("post_reset_underrun", underrun_o, 1);

        // 300 starved fetches forced by enable toggling; counter saturates
        for (int i = 1; i <= 300; i++) begin
            expect_pair(16'h0000, 16'h0000);
            enable = 1'b0;
            @(posedge clk); #1;
            enable = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            if (i == 253) chk("sat_254", underrun_o, 254);
            if (i == 254) chk("sat_255", underrun_o, 255);
        end
        chk("sat_hold", underrun_o, 255);

        // A fresh pair after saturation is still serialized once
        send(16'h8421, 16'h1248, w);
        expect_pair(16'h8421, 16'h1248);
        wait_fetch(600, "final_fetch");
        @(posedge clk); #1;
        chk("final_underrun", underrun_o, 255);
        repeat (260) begin @(posedge clk); #1; end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
